// File: rtl/systolic_pq_shiftq.sv
// systolic_pq_shiftq
//   Min-first priority queue of DEPTH key/value entries built from a linear
//   array of compare-and-shift cells. Cell 0 always holds the smallest key;
//   equal keys leave in arrival order. The value field is carried unchanged.
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset (clears every cell)
//   push_valid_i  producer offers push_data_i
//   push_ready_o  queue can accept an entry (!full)
//   push_data_i   {key[KW+VW-1:VW], value[VW-1:0]}
//   pop_valid_o   head entry valid (!empty)
//   pop_ready_i   consumer takes the head entry
//   pop_data_o    head entry, straight from cell 0 (0 when empty)
//   count_o       number of occupied cells
//   full_o        count_o == DEPTH
//   empty_o       count_o == 0
//   max_data_o    entry in cell count-1 (0 when empty); only present when
//                 SYSTOLIC_PQ_PEEK_MAX_EN is defined
//
// Optional feature macro: SYSTOLIC_PQ_PEEK_MAX_EN

module systolic_pq_shiftq #(
   parameter int unsigned KW    = 8,
   parameter int unsigned VW    = 4,
   parameter int unsigned DEPTH = 8
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         push_valid_i,
   output logic                         push_ready_o,
   input  logic [KW+VW-1:0]             push_data_i,
   output logic                         pop_valid_o,
   input  logic                         pop_ready_i,
   output logic [KW+VW-1:0]             pop_data_o,
   output logic [$clog2(DEPTH+1)-1:0]   count_o,
   output logic                         full_o,
`ifdef SYSTOLIC_PQ_PEEK_MAX_EN
   output logic [KW+VW-1:0]             max_data_o,
`endif
   output logic                         empty_o
);

   localparam int unsigned EW = KW + VW;
   localparam int unsigned CW = $clog2(DEPTH + 1);

   // Per-cell update selection.
   typedef enum logic [1:0] {
      CellHold,
      CellShiftUp,
      CellShiftDown,
      CellLoad
   } cell_mode_e;

   logic [DEPTH-1:0][EW-1:0] data_q, data_d;
   logic [DEPTH-1:0]         occ_q, occ_d;
   logic [CW-1:0]            count_q, count_d;

   // Cell contents as they look after an optional pop (shifted down by one).
   logic [DEPTH-1:0][KW-1:0] eff_key;
   logic [DEPTH-1:0]         eff_occ;
   // after[i]: the insertion point lies at or below cell i. Because keys are
   // sorted and free cells sit on top, this vector is thermometer-shaped.
   logic [DEPTH-1:0]         after;

   logic          full, empty;
   logic          push_fire, pop_fire;
   logic [KW-1:0] new_key;

   assign full      = (count_q == CW'(DEPTH));
   assign empty     = (count_q == '0);
   assign push_fire = push_valid_i & ~full;
   assign pop_fire  = pop_ready_i & ~empty;
   assign new_key   = push_data_i[EW-1 -: KW];

   for (genvar g = 0; g < DEPTH; g++) begin : g_cell
      logic [EW-1:0] above_data, below_data;
      logic          above_occ, below_occ, below_after;
      cell_mode_e    mode;

      if (g < DEPTH - 1) begin : g_above
         assign above_data = data_q[g+1];
         assign above_occ  = occ_q[g+1];
      end else begin : g_top
         assign above_data = '0;
         assign above_occ  = 1'b0;
      end

      if (g > 0) begin : g_below
         assign below_data  = data_q[g-1];
         assign below_occ   = occ_q[g-1];
         assign below_after = after[g-1];
      end else begin : g_bottom
         assign below_data  = '0;
         assign below_occ   = 1'b0;
         assign below_after = 1'b0;
      end

      assign eff_key[g] = pop_fire ? above_data[EW-1 -: KW] : data_q[g][EW-1 -: KW];
      assign eff_occ[g] = pop_fire ? above_occ : occ_q[g];
      // Strictly greater keeps equal keys in arrival order.
      assign after[g]   = ~eff_occ[g] | (eff_key[g] > new_key);

      always_comb begin
         mode = pop_fire ? CellShiftDown : CellHold;
         if (push_fire && after[g]) begin
            if (!below_after) begin
               mode = CellLoad;
            end else begin
               // Above the insertion point: the post-pop view of the lower
               // neighbour is this cell itself when popping.
               mode = pop_fire ? CellHold : CellShiftUp;
            end
         end
      end

      always_comb begin
         data_d[g] = data_q[g];
         occ_d[g]  = occ_q[g];
         unique case (mode)
            CellShiftUp: begin
               data_d[g] = below_data;
               occ_d[g]  = below_occ;
            end
            CellShiftDown: begin
               data_d[g] = above_data;
               occ_d[g]  = above_occ;
            end
            CellLoad: begin
               data_d[g] = push_data_i;
               occ_d[g]  = 1'b1;
            end
            default: begin
               data_d[g] = data_q[g];
               occ_d[g]  = occ_q[g];
            end
         endcase
      end
   end

   always_comb begin
      count_d = count_q;
      if (push_fire && !pop_fire) begin
         count_d = count_q + 1'b1;
      end else if (pop_fire && !push_fire) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q  <= '0;
         occ_q   <= '0;
         count_q <= '0;
      end else begin
         data_q  <= data_d;
         occ_q   <= occ_d;
         count_q <= count_d;
      end
   end

   assign push_ready_o = ~full;
   assign pop_valid_o  = ~empty;
   assign pop_data_o   = data_q[0];
   assign count_o      = count_q;
   assign full_o       = full;
   assign empty_o      = empty;

`ifdef SYSTOLIC_PQ_PEEK_MAX_EN
   // Top occupied cell; stays 0 when the queue is empty.
   always_comb begin
      max_data_o = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (count_q == CW'(i + 1)) begin
            max_data_o = data_q[i];
         end
      end
   end
`endif

endmodule

// File: doc/systolic_pq_shiftq.md
# systolic_pq_shiftq

Registered min-first priority queue of DEPTH key/value entries, built as a linear array of compare-and-shift cells. It is the extraction side of the systolic PQ datapath: entries are pushed in any order and popped in ascending key order through valid/ready handshakes. Ordering is by key only. The value rides along unchanged, and equal keys leave in arrival order.

## Interface
- KW, 8, key width in bits (unsigned compare)
- VW, 4, value width in bits
- DEPTH, 8, number of entries (≥2)
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- push_valid  in  1  push_data is valid
- push_ready  out  1  queue can accept an entry; equals !full
- push_data  in  KW+VW  entry {key[KW+VW-1:VW], value[VW-1:0]}
- pop_valid  out  1  head entry is valid; equals !empty
- pop_ready  in  1  consumer takes the head entry
- pop_data  out  KW+VW  head entry (smallest key), driven straight from cell 0
- count  out  $clog2(DEPTH+1)  number of occupied cells
- full  out  1  count == DEPTH
- empty  out  1  count == 0

## Operation
- Storage: cells 0..DEPTH-1, each holding an entry and an occupied bit.
- Occupied cells always form the contiguous range 0..count-1, with keys non-decreasing from cell 0 upward.
- push_fire = push_valid & push_ready.
- pop_fire = pop_valid & pop_ready.
- Push only: the new entry goes into the first occupied cell whose key is strictly greater than the new key, or into cell count if no such cell exists. That cell and all occupied cells above it shift up by one. count increments.
- Pop only: cell 0 is removed, cells 1..count-1 shift down by one, and the vacated top cell is cleared to 0. count decrements.
- Push and pop together: the result equals a pop followed by a push in the same cycle. The new key is compared against cells 1..count-1 only, and count is unchanged.
- Push and pop together with count==DEPTH is impossible, because push_ready is 0 when full.
- Push when full: no fire and no state change. The producer holds push_valid/push_data.
- Pop when empty: no fire. pop_ready is ignored.
- Each cell computes its insert decision in parallel: it compares against the incoming key and its lower neighbour's key, and selects hold, shift-up, shift-down, or load-new.
- Unoccupied cells hold all-zero data. pop_data is therefore 0 whenever the queue is empty.
- No internal FSM beyond the count register. full and empty are decoded from count.

## Timing
- Reset (async assert, sync-free release): every cell is 0 and unoccupied; count=0, empty=1, full=0, pop_valid=0, push_ready=1, pop_data=0.
- Reset asserted mid-operation discards all contents immediately. There is no flush handshake.
- Latency: an entry pushed at edge N is visible on pop_data after edge N if it is the new minimum. pop_valid rises in the cycle after the first push into an empty queue.
- A pop at edge N presents the next head on pop_data immediately after edge N. Back-to-back pops run one per cycle.
- Throughput: one push and one pop per cycle.
- Combinational paths: push_ready, pop_valid, full, empty and pop_data come from registers only. There is no path from pop_ready to push_ready.

## Configuration
- SYSTOLIC_PQ_PEEK_MAX_EN defined: adds output port max_data (KW+VW).
  - max_data is the entry in cell count-1, i.e. the largest key; among equal largest keys it is the latest arrival.
  - max_data is 0 when empty and updates on the same edge as the cells.
- SYSTOLIC_PQ_PEEK_MAX_EN undefined: the port and its mux are absent. All other behaviour is identical.

## Test plan
- Ordering (KW=8, VW=4): push {0x30,1}, {0x10,2}, {0x20,3}, then pop continuously → pop_data 0x302 is expected first? No: pops return 0x102, 0x203, 0x301 in that order. count steps 3→2→1→0 and empty=1 at the end.
- Stable ties: push {0x40,1}, {0x40,2}, {0x40,3} → pops return values 1, 2, 3 in that order.
- Full boundary: push 8 entries with keys 0x08 down to 0x01 → full=1, push_ready=0, count=8. A further push_valid with {0x00,F} for 3 cycles leaves the contents unchanged. Popping all 8 then yields keys 0x01..0x08.
- Simultaneous push/pop: queue holds 0x10, 0x30; push 0x20 while popping in the same cycle → pop takes 0x10. count stays 2 and the next pops are 0x20, 0x30.
- Empty behaviour: with pop_ready=1 held and no pushes → pop_valid=0 and pop_data=0. A push into the empty queue with pop_ready=1 in the same cycle is accepted, and pop_valid=1 on the next cycle.
- Async reset: assert rst_n=0 between edges with 5 entries held → count=0, empty=1, pop_data=0 immediately. With SYSTOLIC_PQ_PEEK_MAX_EN defined, max_data=0 as well.
